iir_stream_feeder: RTL and testbench
====================================

# iir_stream_feeder

Synthesizable sample source for the `iir` block. It holds a small preloaded sample memory and three coefficient registers, and streams samples into the filter's VIN/DIN input with a programmable inter-sample gap. It replaces the behavioural stimulus generator when the filter runs on-chip or in FPGA bring-up, and it drives the `iir` ports `VIN`, `DIN`, `b0`, `b1` and `a1` directly.

## Interface
- `WIDTH`, default 13: sample and coefficient width, matching `iir`.
- `DEPTH`, default 16: sample memory entries; must be a power of 2.
- `AW`, default 4: log2(`DEPTH`).
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `LD_EN` in 1: sample memory write strobe.
- `LD_ADDR` in `AW`: sample memory write address.
- `LD_DATA` in `WIDTH`: sample memory write data (two's complement).
- `CFG_WE` in 1: coefficient write strobe.
- `CFG_SEL` in 2: coefficient select; 0 = B0, 1 = B1, 2 = A1, 3 = ignored.
- `CFG_DATA` in `WIDTH`: coefficient write data.
- `START` in 1: begin a stream pass.
- `STOP` in 1: abort the stream.
- `NUM` in `AW`+1: number of samples per pass, 0..`DEPTH`.
- `GAP` in 4: idle cycles between consecutive samples, 0..15.
- `LOOP` in 1: repeat passes until `STOP`.
- `VOUT` out 1: sample valid; drives `iir.VIN`.
- `DOUT` out `WIDTH`: sample; drives `iir.DIN`.
- `B0`, `B1`, `A1` out `WIDTH` each: coefficient registers.
- `BUSY` out 1: stream in progress.
- `DONE` out 1: single-cycle end-of-pass pulse.

## Operation
- FSM states: IDLE, EMIT, WAIT.
  - IDLE: `BUSY`=0. If `START`=1 and `STOP`=0, latch `NUM`, `GAP` and `LOOP` and clear the sample index. Then go to EMIT, or to DONE-only behaviour when `NUM`=0 (see below).
  - EMIT: one cycle with `VOUT`=1 and `DOUT`=mem[idx].
    - If idx = NUM−1: `DONE` pulses next cycle. With `LOOP` the FSM returns to EMIT/WAIT with idx=0; otherwise it goes to IDLE.
    - Otherwise idx increments. The next state is WAIT if GAP>0, else EMIT.
  - WAIT: `VOUT`=0 for exactly GAP cycles, then EMIT.
- `NUM`=0 at `START`: no `VOUT`; `DONE`=1 the next cycle; FSM stays in IDLE.
- `NUM`>`DEPTH`: saturated to `DEPTH`.
- `STOP` in EMIT or WAIT: FSM goes to IDLE at the next edge, `VOUT`=0 from then on, no `DONE`. `STOP` beats `START` in the same cycle.
- `START` while `BUSY`=1 is ignored.
- `LD_EN` and `CFG_WE` while `BUSY`=1 are ignored, so memory and coefficients stay stable mid-stream. While idle, writes take effect at the next edge; a coefficient write is visible on `B0`/`B1`/`A1` the cycle after the strobe.
- `DOUT`=0 whenever `VOUT`=0. There is no arithmetic; samples pass through bit-exact.
- Reset values:
  - `VOUT`, `DONE`, `BUSY`, `DOUT`, `B0`, `B1`, `A1` are all 0.
  - FSM is in IDLE and idx is 0.
  - Sample memory is not reset.
- Reset mid-stream: all of the above apply at the next edge; no `DONE`.

## Timing
- All outputs are registered.
- `START` sampled at edge k: first `VOUT`=1 is in cycle k+1.
- Sample period is GAP+1 cycles. A pass of N samples occupies cycles k+1 .. k+1+(N−1)(GAP+1).
- `BUSY`=1 from cycle k+1 through the last `VOUT` cycle.
- `DONE`=1 in the cycle immediately after the last `VOUT` cycle.
- In `LOOP` mode:
  - With GAP=0 the first sample of the next pass is in the same cycle as `DONE`, so `VOUT` is continuous.
  - With GAP>0 the WAIT period precedes it as usual.
  - `BUSY` stays 1 between passes.
- A memory write at edge j is readable by a stream started at edge j+1 or later.

## Structure
- Shared package `iir_pkg` holds:
  - `WIDTH` default.
  - CFG_SEL encodings: `CFG_B0`, `CFG_B1`, `CFG_A1`.
  - FSM state enum: IDLE, EMIT, WAIT.
- One sub-module, `feeder_mem`: `DEPTH`×`WIDTH`, 1 write / 1 synchronous read port. The read address is issued one cycle ahead so that `DOUT` meets the registered timing above.

## Test plan
- Load mem[0..3] = 1, −1, 4095, −4096; `NUM`=4, `GAP`=0, `START` at edge 10 → `VOUT`=1 in cycles 11–14 with `DOUT` 1, 0x1FFF, 0x0FFF, 0x1000; `DONE` in cycle 15; `BUSY` low in cycle 15.
- Same data, `GAP`=2 → `VOUT` in cycles 11, 14, 17, 20; `DOUT`=0 in between; `DONE` in cycle 21.
- `CFG_WE` with `CFG_SEL`=0/1/2 and data 0x0400/0x0200/0x1E00 → `B0`/`B1`/`A1` hold those values; a write of 0x0001 with `CFG_SEL`=1 during `BUSY` leaves `B1`=0x0200.
- `LOOP`=1, `NUM`=2, `GAP`=0 → `DOUT` alternates mem[0], mem[1] continuously; `DONE` pulses every 2 cycles. `STOP` at edge m → `VOUT`=0 from cycle m+1, no further `DONE`.
- `START` with `NUM`=0 → `DONE` next cycle, `VOUT` never high. `NUM`=20 with `DEPTH`=16 → exactly 16 samples.
- `RST` asserted in the 3rd sample cycle → all outputs 0 at the next edge, including coefficients. A subsequent `START` replays from mem[0] with the memory contents intact.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared sample width, coefficient selects and feeder FSM states for the iir block
package iir_pkg;
    localparam int WIDTH = 13;
    localparam logic [1:0] CFG_B0 = 2'd0;
    localparam logic [1:0] CFG_B1 = 2'd1;
    localparam logic [1:0] CFG_A1 = 2'd2;
    typedef enum logic [1:0] {IDLE, EMIT, WAIT} feeder_state_t;
endpackage

// File: rtl/feeder_mem.sv
// feeder_mem: sample store with one write port and a registered read that clears when not reading
module feeder_mem import iir_pkg::*; #(
    parameter int WIDTH = iir_pkg::WIDTH,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Zero when idle so the output doubles as a valid-gated sample register.
    always_ff @(posedge clk) begin
        rdata <= (rst || !re) ? '0 : mem[raddr];
    end
endmodule

// File: rtl/iir_stream_feeder.sv
// iir_stream_feeder: streams preloaded samples and coefficient registers into the iir filter inputs
module iir_stream_feeder import iir_pkg::*; #(
    parameter int WIDTH = iir_pkg::WIDTH,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD_EN,
    input  logic [AW-1:0]    LD_ADDR,
    input  logic [WIDTH-1:0] LD_DATA,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_SEL,
    input  logic [WIDTH-1:0] CFG_DATA,
    input  logic             START,
    input  logic             STOP,
    input  logic [AW:0]      NUM,
    input  logic [3:0]       GAP,
    input  logic             LOOP,
    output logic             VOUT,
    output logic [WIDTH-1:0] DOUT,
    output logic [WIDTH-1:0] B0,
    output logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] A1,
    output logic             BUSY,
    output logic             DONE
);
    feeder_state_t state, nxt_state;
    logic [AW-1:0] idx, nxt_idx;
    logic [3:0] cnt, nxt_cnt, gap_r;
    logic [AW:0] num_r, num_sat;
    logic loop_r, take, last, nxt_done, cfg_ok;
    assign num_sat = (NUM > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : NUM;
    assign take = (state == IDLE) && START && !STOP;
    assign last = {1'b0, idx} == num_r - 1'b1;
    assign cfg_ok = CFG_WE && !BUSY;
    always_comb begin
        nxt_state = state;
        nxt_idx = idx;
        nxt_cnt = cnt;
        nxt_done = 1'b0;
        case (state)
            IDLE: if (take) begin
                nxt_idx = '0;
                nxt_done = (num_sat == '0);
                nxt_state = (num_sat == '0) ? IDLE : EMIT;
            end
            EMIT: if (STOP) nxt_state = IDLE;
            else begin
                nxt_done = last;
                nxt_idx = last ? '0 : idx + 1'b1;
                nxt_cnt = gap_r;
                nxt_state = (last && !loop_r) ? IDLE : ((gap_r != '0) ? WAIT : EMIT);
            end
            WAIT: if (STOP) nxt_state = IDLE;
            else if (cnt == 4'd1) nxt_state = EMIT;
            else nxt_cnt = cnt - 1'b1;
            default: nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            num_r <= '0;
            gap_r <= '0;
            loop_r <= 1'b0;
            VOUT <= 1'b0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            B0 <= '0;
            B1 <= '0;
            A1 <= '0;
        end else begin
            state <= nxt_state;
            idx <= nxt_idx;
            cnt <= nxt_cnt;
            VOUT <= (nxt_state == EMIT);
            BUSY <= (nxt_state != IDLE);
            DONE <= nxt_done;
            if (take) begin
                num_r <= num_sat;
                gap_r <= GAP;
                loop_r <= LOOP;
            end
            if (cfg_ok && CFG_SEL == CFG_B0) B0 <= CFG_DATA;
            if (cfg_ok && CFG_SEL == CFG_B1) B1 <= CFG_DATA;
            if (cfg_ok && CFG_SEL == CFG_A1) A1 <= CFG_DATA;
        end
    end
    // Address is the sample for the next cycle so DOUT lands together with VOUT.
    feeder_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(CLK),
        .rst(RST),
        .we(LD_EN && !BUSY),
        .waddr(LD_ADDR),
        .wdata(LD_DATA),
        .re(nxt_state == EMIT),
        .raddr(nxt_idx),
        .rdata(DOUT)
    );
endmodule

// File: tb/tb_iir_stream_feeder.sv
// tb_iir_stream_feeder: randomized streams checked against a per-cycle timeline model of the feeder
module tb_iir_stream_feeder;
    localparam int W = 13;
    localparam int D = 16;
    localparam int A = 4;
    logic CLK = 1'b0;
    logic RST, LD_EN, CFG_WE, START, STOP, LOOP;
    logic [A-1:0] LD_ADDR;
    logic [W-1:0] LD_DATA, CFG_DATA;
    logic [1:0] CFG_SEL;
    logic [A:0] NUM;
    logic [3:0] GAP;
    logic VOUT, BUSY, DONE;
    logic [W-1:0] DOUT, B0, B1, A1;
    logic [W-1:0] mem_m [D];
    logic [W-1:0] b0_m, b1_m, a1_m;
    int vecs = 0;
    int errs = 0;

    iir_stream_feeder #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .CLK(CLK), .RST(RST), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_DATA(CFG_DATA), .START(START), .STOP(STOP),
        .NUM(NUM), .GAP(GAP), .LOOP(LOOP), .VOUT(VOUT), .DOUT(DOUT), .B0(B0), .B1(B1),
        .A1(A1), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        {LD_EN, CFG_WE, START, STOP, LOOP} = '0;
        LD_ADDR = '0; LD_DATA = '0; CFG_SEL = '0; CFG_DATA = '0; NUM = '0; GAP = '0;
    endtask

    task automatic check_coefs(input string tag);
        check({tag, ".b0"}, 32'(B0), 32'(b0_m));
        check({tag, ".b1"}, 32'(B1), 32'(b1_m));
        check({tag, ".a1"}, 32'(A1), 32'(a1_m));
    endtask

    task automatic load(input int a, input logic [W-1:0] d);
        @(negedge CLK);
        LD_EN = 1'b1; LD_ADDR = A'(a); LD_DATA = d;
        mem_m[a] = d;
        @(negedge CLK);
        LD_EN = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [W-1:0] d);
        @(negedge CLK);
        CFG_WE = 1'b1; CFG_SEL = sel; CFG_DATA = d;
        if (sel == 2'd0) b0_m = d;
        if (sel == 2'd1) b1_m = d;
        if (sel == 2'd2) a1_m = d;
        @(negedge CLK);
        CFG_WE = 1'b0;
        check_coefs("cfg");
    endtask

    // Sample i of the unbroken stream lands at cycle 1 + i*(gap+1); DONE follows each pass's last sample.
    task automatic run(input int num, input int gap, input bit lp, input int stop_at, input int rst_at, input bit noise);
        int n, p, lv, cut, tmax, k;
        bit act, ve, de, be;
        logic [W-1:0] dv;
        n = (num > D) ? D : num;
        p = gap + 1;
        lv = 1 + (n - 1) * p;
        cut = (stop_at > 0) ? stop_at : 0;
        if (rst_at > 0 && (cut == 0 || rst_at < cut)) cut = rst_at;
        tmax = (cut > 0) ? cut + 3 : ((n == 0) ? 3 : lv + 3);
        START = 1'b1; NUM = (A+1)'(num); GAP = 4'(gap); LOOP = lp;
        for (int t = 1; t <= tmax; t++) begin
            @(negedge CLK);
            act = (cut == 0) || (t <= cut);
            if (n == 0) begin
                ve = 1'b0; be = 1'b0; de = act && (t == 1);
            end else begin
                k = (t - 1) / p;
                ve = act && ((t - 1) % p == 0) && (lp || k < n);
                be = act && (lp || t <= lv);
                de = act && t >= 2 && ((t - 2) % p == 0) && (((t - 2) / p) % n == n - 1)
                     && (lp || (t - 2) / p == n - 1);
            end
            dv = ve ? mem_m[((t - 1) / p) % n] : '0;
            check($sformatf("vout@%0d", t), 32'(VOUT), 32'(ve));
            check($sformatf("dout@%0d", t), 32'(DOUT), 32'(dv));
            check($sformatf("done@%0d", t), 32'(DONE), 32'(de));
            check($sformatf("busy@%0d", t), 32'(BUSY), 32'(be));
            check_coefs($sformatf("coef@%0d", t));
            quiet();
            if (noise && be) begin
                START = 1'($urandom); NUM = (A+1)'($urandom); GAP = 4'($urandom); LOOP = 1'($urandom);
                LD_EN = 1'($urandom); LD_ADDR = A'($urandom); LD_DATA = W'($urandom);
                CFG_WE = (t == 1) ? 1'b1 : 1'($urandom);
                CFG_SEL = (t == 1) ? 2'd1 : 2'($urandom);
                CFG_DATA = (t == 1) ? W'(1) : W'($urandom);
            end
            STOP = (t == stop_at);
            RST = (t == rst_at);
            if (t == rst_at) begin
                b0_m = '0; b1_m = '0; a1_m = '0;
            end
        end
        quiet();
        RST = 1'b0;
    endtask

    initial begin
        int num, gap, stop_at, lv;
        bit lp;
        quiet();
        RST = 1'b1;
        b0_m = '0; b1_m = '0; a1_m = '0;
        repeat (2) @(negedge CLK);
        check("rst.vout", 32'(VOUT), 0);
        check("rst.dout", 32'(DOUT), 0);
        check("rst.done", 32'(DONE), 0);
        check("rst.busy", 32'(BUSY), 0);
        check_coefs("rst");
        RST = 1'b0;
        load(0, 13'h0001); load(1, 13'h1FFF); load(2, 13'h0FFF); load(3, 13'h1000);
        for (int i = 4; i < D; i++) load(i, W'($urandom));
        run(4, 0, 1'b0, 0, 0, 1'b0);
        run(4, 2, 1'b0, 0, 0, 1'b0);
        cfg(2'd0, 13'h0400); cfg(2'd1, 13'h0200); cfg(2'd2, 13'h1E00); cfg(2'd3, 13'h0777);
        run(4, 1, 1'b0, 0, 0, 1'b1);
        run(2, 0, 1'b1, 9, 0, 1'b0);
        run(0, 3, 1'b0, 0, 0, 1'b0);
        run(20, 0, 1'b0, 0, 0, 1'b0);
        run(8, 0, 1'b0, 0, 3, 1'b0);
        run(6, 0, 1'b0, 0, 0, 1'b0);
        run(5, 2, 1'b0, 0, 0, 1'b1);
        cfg(2'd0, 13'h0123); cfg(2'd2, 13'h1ABC);
        for (int s = 0; s < 30; s++) begin
            if (s % 5 == 0) load(int'($urandom_range(0, D - 1)), W'($urandom));
            lp = ($urandom_range(0, 2) == 0);
            num = $urandom_range(0, 20);
            gap = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
            lv = 1 + (((num > D) ? D : num) - 1) * (gap + 1);
            stop_at = lp ? $urandom_range(1, 40) : (($urandom_range(0, 3) == 0 && lv > 1) ? $urandom_range(1, lv) : 0);
            @(negedge CLK);
            run(num, gap, lp, stop_at, 0, 1'($urandom));
        end
        @(negedge CLK);
        RST = 1'b1;
        b0_m = '0; b1_m = '0; a1_m = '0;
        @(negedge CLK);
        RST = 1'b0;
        run(7, 1, 1'b0, 0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
